mul_exec_pipe: RTL and testbench

Execution stage directly downstream of the multiply reservation station. It accepts one issued 57-bit multiply packet per cycle and reads both source operands from the physical register file. It computes the low 32 bits of the unsigned/two's-complement product in a fixed 3-cycle pipeline. It then broadcasts the completion (dest, data, PC) on the MUL result bus that wakes up every reservation station and writes the register file.

---
 rtl/mul_exec_pipe_if.sv | 40 ++++
 rtl/mul_exec_pipe.sv | 125 ++++++++++++
 tb/tb_mul_exec_pipe.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_exec_pipe_if.sv
// mul_exec_pipe_if
// Bundles the issue, flush, register-file read and MUL result-bus signals of
// the multiply execution stage.
//   issue_pkt        {valid, PC, Rd, op1_phy, op2_phy} from the reservation station
//   exception_sig    pipeline flush
//   mret_sig         pipeline flush
//   rf_raddr1/2      register-file read addresses (from the pipe)
//   rf_rdata1/2      register-file read data, one cycle after the address
//   MUL_result_*     completion broadcast (valid, dest tag, data, PC)
// master = station / register-file side, slave = the execution pipe.
interface mul_exec_pipe_if #(
    parameter int XLEN  = 32,
    parameter int PHY_W = 8
);
    localparam int PKT_W = 1 + XLEN + 3 * PHY_W;

    logic [PKT_W-1:0] issue_pkt;
    logic             exception_sig;
    logic             mret_sig;
    logic [PHY_W-1:0] rf_raddr1;
    logic [PHY_W-1:0] rf_raddr2;
    logic [XLEN-1:0]  rf_rdata1;
    logic [XLEN-1:0]  rf_rdata2;
    logic             MUL_result_valid;
    logic [PHY_W-1:0] MUL_result_dest;
    logic [XLEN-1:0]  MUL_result_data;
    logic [XLEN-1:0]  MUL_result_PC;

    modport master (
        output issue_pkt, exception_sig, mret_sig, rf_rdata1, rf_rdata2,
        input  rf_raddr1, rf_raddr2,
        input  MUL_result_valid, MUL_result_dest, MUL_result_data, MUL_result_PC
    );

    modport slave (
        input  issue_pkt, exception_sig, mret_sig, rf_rdata1, rf_rdata2,
        output rf_raddr1, rf_raddr2,
        output MUL_result_valid, MUL_result_dest, MUL_result_data, MUL_result_PC
    );
endinterface

// File: rtl/mul_exec_pipe.sv
// mul_exec_pipe
// Three-stage multiply execution pipe returning the low XLEN bits of the
// product. One packet per cycle, no backpressure, fixed latency of 3 cycles.
//   clk    clock, all state on the rising edge
//   reset  asynchronous active-low reset
//   bus    mul_exec_pipe_if.slave: issue packet, flushes, register-file read
//          port and MUL result bus
// S1 holds the issued packet while the register file returns operands; S2
// holds three partial products; the output stage sums them onto the bus.
module mul_exec_pipe #(
    parameter int XLEN  = 32,
    parameter int PHY_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    mul_exec_pipe_if.slave  bus
);
    localparam int HALF  = XLEN / 2;
    localparam int OP2_L = 0;
    localparam int OP1_L = PHY_W;
    localparam int RD_L  = 2 * PHY_W;
    localparam int PC_L  = 3 * PHY_W;
    localparam int V_B   = 3 * PHY_W + XLEN;

    logic             pkt_valid;
    logic [XLEN-1:0]  pkt_pc;
    logic [PHY_W-1:0] pkt_rd;
    logic [PHY_W-1:0] pkt_op1;
    logic [PHY_W-1:0] pkt_op2;
    logic             flush;

    logic             s1_valid_q;
    logic [XLEN-1:0]  s1_pc_q;
    logic [PHY_W-1:0] s1_rd_q;
    logic [PHY_W-1:0] s1_op1_q;
    logic [PHY_W-1:0] s1_op2_q;

    logic             s2_valid_q;
    logic [XLEN-1:0]  s2_pc_q;
    logic [PHY_W-1:0] s2_rd_q;
    logic [XLEN-1:0]  pp0_q;
    logic [HALF-1:0]  pp1_q;
    logic [HALF-1:0]  pp2_q;

    logic             res_valid_q;
    logic [PHY_W-1:0] res_dest_q;
    logic [XLEN-1:0]  res_data_q;
    logic [XLEN-1:0]  res_pc_q;

    logic [XLEN-1:0]  opa;
    logic [XLEN-1:0]  opb;
    logic [XLEN-1:0]  pp0_d;
    logic [HALF-1:0]  pp1_d;
    logic [HALF-1:0]  pp2_d;
    logic [XLEN-1:0]  res_data_d;

    assign pkt_valid = bus.issue_pkt[V_B];
    assign pkt_pc    = bus.issue_pkt[PC_L +: XLEN];
    assign pkt_rd    = bus.issue_pkt[RD_L +: PHY_W];
    assign pkt_op1   = bus.issue_pkt[OP1_L +: PHY_W];
    assign pkt_op2   = bus.issue_pkt[OP2_L +: PHY_W];
    assign flush     = bus.exception_sig | bus.mret_sig;

    // Read addresses go straight from the packet so the register file's
    // synchronous read lines up with S1.
    assign bus.rf_raddr1 = pkt_op1;
    assign bus.rf_raddr2 = pkt_op2;

    // A producer issued two cycles earlier is on the result bus during this
    // consumer's S1 cycle, before the register file holds its value.
    assign opa = (res_valid_q && (res_dest_q == s1_op1_q)) ? res_data_q : bus.rf_rdata1;
    assign opb = (res_valid_q && (res_dest_q == s1_op2_q)) ? res_data_q : bus.rf_rdata2;

    // Only the low half of the cross terms can reach the low XLEN result bits;
    // the high*high term is dropped entirely.
    assign pp0_d = {{HALF{1'b0}}, opa[HALF-1:0]} * {{HALF{1'b0}}, opb[HALF-1:0]};
    assign pp1_d = opa[HALF-1:0] * opb[XLEN-1:HALF];
    assign pp2_d = opa[XLEN-1:HALF] * opb[HALF-1:0];

    assign res_data_d = pp0_q + {pp1_q + pp2_q, {HALF{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_pc_q     <= '0;
            s1_rd_q     <= '0;
            s1_op1_q    <= '0;
            s1_op2_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_pc_q     <= '0;
            s2_rd_q     <= '0;
            pp0_q       <= '0;
            pp1_q       <= '0;
            pp2_q       <= '0;
            res_valid_q <= 1'b0;
            res_dest_q  <= '0;
            res_data_q  <= '0;
            res_pc_q    <= '0;
        end else begin
            // Flush only clears valid bits; payloads are don't-care when invalid.
            s1_valid_q  <= pkt_valid & ~flush;
            s1_pc_q     <= pkt_pc;
            s1_rd_q     <= pkt_rd;
            s1_op1_q    <= pkt_op1;
            s1_op2_q    <= pkt_op2;

            s2_valid_q  <= s1_valid_q & ~flush;
            s2_pc_q     <= s1_pc_q;
            s2_rd_q     <= s1_rd_q;
            pp0_q       <= pp0_d;
            pp1_q       <= pp1_d;
            pp2_q       <= pp2_d;

            res_valid_q <= s2_valid_q & ~flush;
            res_dest_q  <= s2_rd_q;
            res_data_q  <= res_data_d;
            res_pc_q    <= s2_pc_q;
        end
    end

    assign bus.MUL_result_valid = res_valid_q;
    assign bus.MUL_result_dest  = res_dest_q;
    assign bus.MUL_result_data  = res_data_q;
    assign bus.MUL_result_PC    = res_pc_q;
endmodule

// File: tb/tb_mul_exec_pipe.sv
// tb_mul_exec_pipe
// Directed and random stimulus for mul_exec_pipe, checked each cycle against a
// cycle-indexed reference: a packet issued in cycle c completes in c+3 with
// (opA*opB) mod 2^32 unless a flush or reset lands in c, c+1 or c+2.
module tb_mul_exec_pipe;
    localparam int MAXC = 1024;

    logic clk;
    logic reset;

    mul_exec_pipe_if bus ();

    mul_exec_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit rel_pending = 0;

    bit          pv    [MAXC];
    logic [31:0] ppc   [MAXC];
    logic [7:0]  prd   [MAXC];
    logic [7:0]  pop1  [MAXC];
    logic [7:0]  pop2  [MAXC];
    bit          kill  [MAXC];
    bit          exp_v [MAXC+4];
    logic [7:0]  exp_d [MAXC+4];
    logic [31:0] exp_x [MAXC+4];
    logic [31:0] exp_pc[MAXC+4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, expv);
    endtask

    function automatic logic [56:0] mk(input bit v, input logic [31:0] pc, input logic [7:0] rd,
                                       input logic [7:0] o1, input logic [7:0] o2);
        return {v, pc, rd, o1, o2};
    endfunction

    function automatic logic [56:0] bub();
        return mk(1'b0, $urandom, 8'($urandom), 8'($urandom), 8'($urandom));
    endfunction

    // One cycle: check this cycle's outputs, drive this cycle's inputs, update the model.
    task automatic step(input logic [56:0] pkt, input logic [1:0] fl,
                        input logic [31:0] d1, input logic [31:0] d2);
        logic [31:0] a, b;
        @(negedge clk);
        if (rel_pending) begin
            reset = 1'b1;
            rel_pending = 0;
        end
        chk("valid", {63'b0, bus.MUL_result_valid}, {63'b0, exp_v[cyc]});
        if (exp_v[cyc]) begin
            chk("dest", {56'b0, bus.MUL_result_dest}, {56'b0, exp_d[cyc]});
            chk("data", {32'b0, bus.MUL_result_data}, {32'b0, exp_x[cyc]});
            chk("pc",   {32'b0, bus.MUL_result_PC},   {32'b0, exp_pc[cyc]});
        end
        bus.issue_pkt     = pkt;
        bus.exception_sig = fl[1];
        bus.mret_sig      = fl[0];
        bus.rf_rdata1     = d1;
        bus.rf_rdata2     = d2;
        #1;
        chk("raddr1", {56'b0, bus.rf_raddr1}, {56'b0, pkt[15:8]});
        chk("raddr2", {56'b0, bus.rf_raddr2}, {56'b0, pkt[7:0]});

        pv[cyc]   = pkt[56];
        ppc[cyc]  = pkt[55:24];
        prd[cyc]  = pkt[23:16];
        pop1[cyc] = pkt[15:8];
        pop2[cyc] = pkt[7:0];
        kill[cyc] = |fl;
        if (cyc >= 1 && pv[cyc-1] && !kill[cyc-1] && !kill[cyc]) begin
            a = (exp_v[cyc] && exp_d[cyc] == pop1[cyc-1]) ? exp_x[cyc] : d1;
            b = (exp_v[cyc] && exp_d[cyc] == pop2[cyc-1]) ? exp_x[cyc] : d2;
            exp_v[cyc+2]  = 1;
            exp_d[cyc+2]  = prd[cyc-1];
            exp_x[cyc+2]  = a * b;
            exp_pc[cyc+2] = ppc[cyc-1];
        end
        if (kill[cyc]) begin
            exp_v[cyc+1] = 0;
            exp_v[cyc+2] = 0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(bub(), 2'b00, $urandom, $urandom);
    endtask

    // Reset asserted between edges of the cycle just stepped.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_valid", {63'b0, bus.MUL_result_valid}, 64'd0);
        chk("rst_dest",  {56'b0, bus.MUL_result_dest},  64'd0);
        chk("rst_data",  {32'b0, bus.MUL_result_data},  64'd0);
        chk("rst_pc",    {32'b0, bus.MUL_result_PC},    64'd0);
        kill[cyc-1]  = 1;
        exp_v[cyc]   = 0;
        exp_v[cyc+1] = 0;
        rel_pending  = 1;
    endtask

    initial begin
        logic [7:0] rd, o1, o2;
        logic [1:0] fl;
        for (int i = 0; i < MAXC; i++) begin
            pv[i] = 0;
            kill[i] = 0;
        end
        for (int i = 0; i < MAXC + 4; i++) exp_v[i] = 0;

        reset = 1'b0;
        bus.issue_pkt     = mk(1'b1, 32'h1234, 8'h11, 8'hA5, 8'h5A);
        bus.exception_sig = 1'b0;
        bus.mret_sig      = 1'b0;
        bus.rf_rdata1     = '0;
        bus.rf_rdata2     = '0;
        #1;
        chk("init_valid", {63'b0, bus.MUL_result_valid}, 64'd0);
        chk("init_dest",  {56'b0, bus.MUL_result_dest},  64'd0);
        chk("init_data",  {32'b0, bus.MUL_result_data},  64'd0);
        chk("init_pc",    {32'b0, bus.MUL_result_PC},    64'd0);
        chk("init_raddr1", {56'b0, bus.rf_raddr1}, 64'hA5);
        chk("init_raddr2", {56'b0, bus.rf_raddr2}, 64'h5A);
        rel_pending = 1;

        // basic: 7*6 = 42
        step(mk(1, 32'h100, 8'h21, 8'h05, 8'h06), 2'b00, 0, 0);
        step(bub(), 2'b00, 32'd7, 32'd6);
        idle(3);

        // wrap / sign cases back to back
        step(mk(1, 32'h200, 8'h41, 8'h01, 8'h02), 2'b00, 0, 0);
        step(mk(1, 32'h204, 8'h42, 8'h03, 8'h04), 2'b00, 32'hFFFF_FFFF, 32'h2);
        step(mk(1, 32'h208, 8'h43, 8'h05, 8'h06), 2'b00, 32'h0001_0000, 32'h0001_0000);
        step(bub(), 2'b00, 32'h0001_0001, 32'h0001_0001);
        idle(3);

        // streaming + self-bypass: A=3*4 to 0x30, B uses 0x30 with stale rf data
        step(mk(1, 32'h300, 8'h30, 8'h07, 8'h08), 2'b00, 0, 0);
        step(bub(), 2'b00, 32'd3, 32'd4);
        step(mk(1, 32'h304, 8'h31, 8'h30, 8'h09), 2'b00, 0, 0);
        step(bub(), 2'b00, 32'd0, 32'd5);
        idle(3);

        // flush in c+2 kills three packets, packet in c+3 completes
        step(mk(1, 32'h400, 8'h50, 8'h01, 8'h02), 2'b00, 0, 0);
        step(mk(1, 32'h404, 8'h51, 8'h01, 8'h02), 2'b00, 32'd9, 32'd9);
        step(mk(1, 32'h408, 8'h52, 8'h01, 8'h02), 2'b10, 32'd9, 32'd9);
        step(mk(1, 32'h40C, 8'h53, 8'h03, 8'h04), 2'b00, 32'd9, 32'd9);
        step(bub(), 2'b00, 32'd11, 32'd13);
        idle(3);

        // mret flush with a packet in the same cycle
        step(mk(1, 32'h500, 8'h54, 8'h01, 8'h02), 2'b01, 0, 0);
        step(bub(), 2'b00, 32'd5, 32'd5);
        idle(3);

        // async reset while a result is on the bus, then a fresh packet
        step(mk(1, 32'h600, 8'h60, 8'h0A, 8'h0B), 2'b00, 0, 0);
        step(mk(1, 32'h604, 8'h61, 8'h0A, 8'h0B), 2'b00, 32'h1234_5678, 32'h9ABC_DEF1);
        step(bub(), 2'b00, 32'd2, 32'd2);
        step(bub(), 2'b00, 0, 0);
        async_reset();
        step(mk(1, 32'h700, 8'h00, 8'h0C, 8'h0D), 2'b00, 0, 0);
        step(bub(), 2'b00, 32'hDEAD_BEEF, 32'h0000_0003);
        idle(3);

        // bubble stream
        idle(10);

        // random traffic with tight tag reuse to exercise the bypass
        for (int i = 0; i < 500; i++) begin
            rd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h30 + $urandom_range(0, 3));
            o1 = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'(8'h30 + $urandom_range(0, 3));
            o2 = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'(8'h30 + $urandom_range(0, 3));
            case ($urandom_range(0, 19))
                0:       fl = 2'b10;
                1:       fl = 2'b01;
                default: fl = 2'b00;
            endcase
            step(mk($urandom_range(0, 3) != 0, $urandom, rd, o1, o2), fl,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
